// File: rtl/ball_motion_ctrl_if.sv
// rtl/ball_motion_ctrl_if.sv - frame-sync inputs and committed ball positions for ball_motion_ctrl
interface ball_motion_ctrl_if #(
    parameter int NUM_BALLS = 2
);
    logic                    v_sync;
    logic                    freeze;
    logic [10*NUM_BALLS-1:0] ball_x;
    logic [10*NUM_BALLS-1:0] ball_y;
    logic                    busy;
    logic                    frame_done;
    logic [15:0]             frame_count;

    // Side that produces v_sync/freeze and consumes positions (vga + pixel datapath)
    modport master (
        output v_sync,
        output freeze,
        input  ball_x,
        input  ball_y,
        input  busy,
        input  frame_done,
        input  frame_count
    );

    // The motion controller itself
    modport slave (
        input  v_sync,
        input  freeze,
        output ball_x,
        output ball_y,
        output busy,
        output frame_done,
        output frame_count
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame time-multiplexed ball position scheduler with wall bounce
module ball_motion_ctrl #(
    parameter int                         NUM_BALLS     = 2,
    parameter int                         BALL_SPEED    = 5,
    parameter int                         SCREEN_WIDTH  = 800,
    parameter int                         SCREEN_HEIGHT = 600,
    parameter int                         BALL_DIM      = 25,
    parameter logic [10*NUM_BALLS-1:0]    START_X       = {10'd400, 10'd150},
    parameter logic [10*NUM_BALLS-1:0]    START_Y       = {10'd300, 10'd100}
) (
    input  logic               clk_100mhz,
    input  logic               reset_n,
    ball_motion_ctrl_if.slave  bus
);

    localparam int              IDX_W    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [10:0]     X_MAX    = 11'(SCREEN_WIDTH - BALL_DIM);
    localparam logic [10:0]     Y_MAX    = 11'(SCREEN_HEIGHT - BALL_DIM);
    localparam logic [10:0]     STEP     = 11'(BALL_SPEED);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPD_X  = 2'd1,
        S_UPD_Y  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    vs_q;
    logic                    start_evt;

    // Shadow positions and directions (1 = increasing); outputs only see them at commit
    logic [9:0]              sx [NUM_BALLS];
    logic [9:0]              sy [NUM_BALLS];
    logic [NUM_BALLS-1:0]    vx;
    logic [NUM_BALLS-1:0]    vy;

    logic [10*NUM_BALLS-1:0] ball_x_q;
    logic [10*NUM_BALLS-1:0] ball_y_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic [15:0]             frame_count_q;

    // Shared add/subtract unit operands and results
    logic                    sel_y;
    logic [10:0]             cur_pos;
    logic                    cur_dir;
    logic [10:0]             cur_max;
    logic [10:0]             pos_inc;
    logic [10:0]             pos_dec;
    logic                    hit_hi;
    logic                    hit_lo;
    logic [10:0]             new_pos;
    logic                    new_dir;

    assign start_evt = vs_q & ~bus.v_sync;

    // Single stepping unit, muxed onto the coordinate selected by state and idx
    always_comb begin
        sel_y   = (state == S_UPD_Y);
        cur_pos = sel_y ? {1'b0, sy[idx]} : {1'b0, sx[idx]};
        cur_dir = sel_y ? vy[idx] : vx[idx];
        cur_max = sel_y ? Y_MAX : X_MAX;
        pos_inc = cur_pos + STEP;
        pos_dec = cur_pos - STEP;
        hit_hi  = (pos_inc >= cur_max);
        hit_lo  = (cur_pos <= STEP);
        new_pos = cur_pos;
        new_dir = cur_dir;
        if (cur_dir) begin
            if (hit_hi) begin
                new_pos = cur_max;
                new_dir = 1'b0;
            end else begin
                new_pos = pos_inc;
            end
        end else begin
            if (hit_lo) begin
                new_pos = 11'd0;
                new_dir = 1'b1;
            end else begin
                new_pos = pos_dec;
            end
        end
    end

    // Next-state logic: walk X then Y of each ball, then commit in one cycle
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start_evt && !bus.freeze) begin
                    state_nxt = S_UPD_X;
                    idx_nxt   = '0;
                end
            end
            S_UPD_X: begin
                state_nxt = S_UPD_Y;
            end
            S_UPD_Y: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_COMMIT;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_UPD_X;
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, ball index and v_sync history
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            idx   <= '0;
            vs_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            vs_q  <= bus.v_sync;
        end
    end

    // Shadow coordinate update, one coordinate per clock
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                sx[i] <= START_X[10*i +: 10];
                sy[i] <= START_Y[10*i +: 10];
            end
            vx <= '1;
            vy <= '1;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx == IDX_W'(i)) begin
                    if (state == S_UPD_X) begin
                        sx[i] <= new_pos[9:0];
                        vx[i] <= new_dir;
                    end
                    if (state == S_UPD_Y) begin
                        sy[i] <= new_pos[9:0];
                        vy[i] <= new_dir;
                    end
                end
            end
        end
    end

    // Output registers: whole frame committed at once, plus status flags
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            ball_x_q      <= START_X;
            ball_y_q      <= START_Y;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            busy_q       <= (state_nxt != S_IDLE) || (state == S_COMMIT);
            frame_done_q <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    ball_x_q[10*i +: 10] <= sx[i];
                    ball_y_q[10*i +: 10] <= sy[i];
                end
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

    localparam int SPEED = 5;
    localparam int XMAX  = 775;
    localparam int YMAX  = 575;

    logic clk_100mhz = 1'b0;
    logic reset_n;

    always #5 clk_100mhz = ~clk_100mhz;

    ball_motion_ctrl_if #(.NUM_BALLS(2)) bus_a ();
    ball_motion_ctrl_if #(.NUM_BALLS(2)) bus_b ();

    ball_motion_ctrl dut_a (
        .clk_100mhz (clk_100mhz),
        .reset_n    (reset_n),
        .bus        (bus_a)
    );

    ball_motion_ctrl #(
        .START_X ({10'd400, 10'd772}),
        .START_Y ({10'd574, 10'd100})
    ) dut_b (
        .clk_100mhz (clk_100mhz),
        .reset_n    (reset_n),
        .bus        (bus_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model for dut_a: positions and direction of travel per ball
    int mx [2];
    int my [2];
    int dx [2];
    int dy [2];
    int mfc;

    typedef struct {
        bit          frz;
        logic [19:0] ex;
        logic [19:0] ey;
        logic [15:0] fc;
        int          pulses;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mx[0] = 150; mx[1] = 400;
        my[0] = 100; my[1] = 300;
        dx[0] = 1; dx[1] = 1; dy[0] = 1; dy[1] = 1;
        mfc = 0;
    endfunction

    // Move by one step in the travel direction; clamp at a wall and reverse
    function automatic void move(inout int p, inout int d, input int lim);
        int q;
        q = p + (d != 0 ? SPEED : -SPEED);
        if (q >= lim) begin
            p = lim; d = 0;
        end else if (q <= 0) begin
            p = 0; d = 1;
        end else begin
            p = q;
        end
    endfunction

    function automatic void model_frame();
        for (int b = 0; b < 2; b++) begin
            move(mx[b], dx[b], XMAX);
            move(my[b], dy[b], YMAX);
        end
        mfc = (mfc + 1) % 65536;
    endfunction

    function automatic logic [19:0] pack2(input int lo, input int hi);
        logic [9:0] a;
        logic [9:0] b;
        a = 10'(lo);
        b = 10'(hi);
        return {b, a};
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_x"}, 32'(bus_a.ball_x), 32'(pack2(mx[0], mx[1])));
        check({tag, "_y"}, 32'(bus_a.ball_y), 32'(pack2(my[0], my[1])));
        check({tag, "_fc"}, 32'(bus_a.frame_count), 32'(mfc));
    endtask

    // One v_sync fall on the selected DUT; observe a bounded window afterwards
    task automatic frame(input int sel, input bit frz, output int pulses, output int busy_seen);
        pulses = 0;
        busy_seen = 0;
        @(negedge clk_100mhz);
        if (sel == 0) begin bus_a.v_sync = 1'b0; bus_a.freeze = frz; end
        else          begin bus_b.v_sync = 1'b0; bus_b.freeze = frz; end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100mhz);
            if (sel == 0) begin
                if (bus_a.frame_done) pulses++;
                if (bus_a.busy) busy_seen++;
            end else begin
                if (bus_b.frame_done) pulses++;
                if (bus_b.busy) busy_seen++;
            end
        end
        if (sel == 0) begin bus_a.v_sync = 1'b1; bus_a.freeze = 1'b0; end
        else          begin bus_b.v_sync = 1'b1; bus_b.freeze = 1'b0; end
        @(negedge clk_100mhz);
    endtask

    initial begin
        int pulses;
        int busy_seen;
        bit frz;

        vecs[0] = '{frz: 1'b0, ex: {10'd405, 10'd775}, ey: {10'd575, 10'd105}, fc: 16'd1, pulses: 1};
        vecs[1] = '{frz: 1'b1, ex: {10'd405, 10'd775}, ey: {10'd575, 10'd105}, fc: 16'd1, pulses: 0};
        vecs[2] = '{frz: 1'b0, ex: {10'd410, 10'd770}, ey: {10'd570, 10'd110}, fc: 16'd2, pulses: 1};
        vecs[3] = '{frz: 1'b0, ex: {10'd415, 10'd765}, ey: {10'd565, 10'd115}, fc: 16'd3, pulses: 1};

        reset_n = 1'b0;
        bus_a.v_sync = 1'b1; bus_a.freeze = 1'b0;
        bus_b.v_sync = 1'b1; bus_b.freeze = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_100mhz);

        check("rst_x", 32'(bus_a.ball_x), 32'(pack2(150, 400)));
        check("rst_y", 32'(bus_a.ball_y), 32'(pack2(100, 300)));
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.frame_done), 32'd0);
        check("rst_fc", 32'(bus_a.frame_count), 32'd0);
        check("rst_b_x", 32'(bus_b.ball_x), 32'(pack2(772, 400)));
        reset_n = 1'b1;
        repeat (2) @(negedge clk_100mhz);

        // Wall-bounce and freeze table on dut_b
        for (int v = 0; v < 4; v++) begin
            frame(1, vecs[v].frz, pulses, busy_seen);
            check($sformatf("tbl%0d_pulses", v), 32'(pulses), 32'(vecs[v].pulses));
            check($sformatf("tbl%0d_x", v), 32'(bus_b.ball_x), 32'(vecs[v].ex));
            check($sformatf("tbl%0d_y", v), 32'(bus_b.ball_y), 32'(vecs[v].ey));
            check($sformatf("tbl%0d_fc", v), 32'(bus_b.frame_count), 32'(vecs[v].fc));
            if (vecs[v].frz) check($sformatf("tbl%0d_busy", v), 32'(busy_seen), 32'd0);
        end

        // Single frame with exact commit timing on dut_a
        @(negedge clk_100mhz);
        bus_a.v_sync = 1'b0;
        @(negedge clk_100mhz);
        check("sf_busy_e", 32'(bus_a.busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_100mhz);
            check($sformatf("sf_hold_x_%0d", k), 32'(bus_a.ball_x), 32'(pack2(150, 400)));
            check($sformatf("sf_nodone_%0d", k), 32'(bus_a.frame_done), 32'd0);
        end
        @(negedge clk_100mhz);
        model_frame();
        check("sf_done_e5", 32'(bus_a.frame_done), 32'd1);
        check("sf_busy_e5", 32'(bus_a.busy), 32'd1);
        check("sf_x", 32'(bus_a.ball_x), 32'(pack2(155, 405)));
        check("sf_y", 32'(bus_a.ball_y), 32'(pack2(105, 305)));
        check("sf_fc", 32'(bus_a.frame_count), 32'd1);
        @(negedge clk_100mhz);
        check("sf_done_e6", 32'(bus_a.frame_done), 32'd0);
        check("sf_busy_e6", 32'(bus_a.busy), 32'd0);
        bus_a.v_sync = 1'b1;
        @(negedge clk_100mhz);

        // Freeze: no activity, positions held
        frame(0, 1'b1, pulses, busy_seen);
        check("frz_pulses", 32'(pulses), 32'd0);
        check("frz_busy", 32'(busy_seen), 32'd0);
        check_model("frz");

        // v_sync glitch during busy gives exactly one commit, held-low does not retrigger
        @(negedge clk_100mhz);
        bus_a.v_sync = 1'b0;
        @(negedge clk_100mhz);
        bus_a.v_sync = 1'b1;
        @(negedge clk_100mhz);
        bus_a.v_sync = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_100mhz);
            if (bus_a.frame_done) pulses++;
        end
        model_frame();
        check("glitch_pulses", 32'(pulses), 32'd1);
        check_model("glitch");
        bus_a.v_sync = 1'b1;
        @(negedge clk_100mhz);

        // Reset mid-update at E+2
        @(negedge clk_100mhz);
        bus_a.v_sync = 1'b0;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        @(posedge clk_100mhz);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_x", 32'(bus_a.ball_x), 32'(pack2(150, 400)));
        check("mid_rst_y", 32'(bus_a.ball_y), 32'(pack2(100, 300)));
        check("mid_rst_fc", 32'(bus_a.frame_count), 32'd0);
        check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
        bus_a.v_sync = 1'b1;
        repeat (2) @(negedge clk_100mhz);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100mhz);
            if (bus_a.frame_done) pulses++;
        end
        check("mid_rst_nodone", 32'(pulses), 32'd0);
        check_model("mid_rst");

        // Randomized frames against the model, long enough to hit every wall
        for (int f = 0; f < 360; f++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_100mhz);
            frz = ($urandom_range(0, 3) == 0);
            frame(0, frz, pulses, busy_seen);
            if (!frz) model_frame();
            check($sformatf("rnd%0d_pulses", f), 32'(pulses), frz ? 32'd0 : 32'd1);
            check_model($sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
